tlp2dllp: RTL and testbench

//  Transmit-side PCIe data-link framer. It turns TL TLPs into link frames: {seq-num hdr, TLP, LCRC}.
//  It muxes in pre-built DLLPs (Ack/Nak/FC) at frame boundaries, giving one stream toward the PHY.
//  The 12-bit NEXT_TRANSMIT_SEQ counter lives here; each framed seq is reported to the retry buffer.

---
 rtl/pcie_datalink_pkg.sv | 33 +++
 rtl/pcie_lcrc32.sv | 26 ++
 rtl/tlp2dllp.sv | 183 ++++++++++++++++++
 tb/tb_tlp2dllp.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_datalink_pkg.sv
// Shared data-link definitions: link status, TX framer states and LCRC constants.
// The LCRC helper converts the running remainder into the order the bytes leave on the link.
package pcie_datalink_pkg;

   localparam int          SEQ_W     = 12;
   localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] LCRC_SEED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DL_INACTIVE = 2'd0,
      DL_INIT     = 2'd1,
      DL_ACTIVE   = 2'd2
   } dl_status_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_DLLP_PASS,
      TX_TLP_FIRST,
      TX_TLP_BODY,
      TX_CRC_A,
      TX_CRC_B
   } tx_fsm_e;

   // Complement, then reverse bits within each byte; wire byte 0 carries remainder[31:24].
   function automatic logic [31:0] lcrc_final(input logic [31:0] crc);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = ~crc[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/pcie_lcrc32.sv
// Combinational CRC-32 step over the low 1..4 bytes selected by keep, each byte fed LSB first.
// Shared between the transmit framer and the receive checker.
module pcie_lcrc32
   import pcie_datalink_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  keep_i,
   output logic [31:0] crc_o
);

   logic [31:0] acc;

   always_comb begin
      acc = crc_i;
      for (int b = 0; b < 4; b++) begin
         if (keep_i[b]) begin
            for (int i = 0; i < 8; i++) begin
               acc = {acc[30:0], 1'b0} ^ ((acc[31] ^ data_i[8*b+i]) ? LCRC_POLY : 32'h0);
            end
         end
      end
      crc_o = acc;
   end

endmodule

// File: rtl/tlp2dllp.sv
// Transmit data-link framer: prefixes TLPs with the sequence number, appends the LCRC,
// and interleaves pre-built DLLPs at frame boundaries onto one registered output stream.
module tlp2dllp
   import pcie_datalink_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  dl_status_e            link_status_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata_i,
   input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep_i,
   input  logic                  s_axis_tlp_tvalid_i,
   input  logic                  s_axis_tlp_tlast_i,
   output logic                  s_axis_tlp_tready_o,
   input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
   input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
   input  logic                  s_axis_dllp_tvalid_i,
   input  logic                  s_axis_dllp_tlast_i,
   output logic                  s_axis_dllp_tready_o,
   output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
   output logic                  m_axis_tvalid_o,
   output logic                  m_axis_tlast_o,
   output logic [USER_WIDTH-1:0] m_axis_tuser_o,
   input  logic                  m_axis_tready_i,
   output logic [SEQ_W-1:0]      tx_seq_num_o,
   output logic                  tx_seq_valid_o
);

   tx_fsm_e               state, state_nxt;
   logic [SEQ_W-1:0]      next_seq;
   logic [31:0]           crc, crc_upd, lcrc_a, lcrc_b;
   logic [15:0]           carry;
   logic [31:0]           crc_data;
   logic [3:0]            crc_keep;

   logic                  m_valid, m_last;
   logic [DATA_WIDTH-1:0] m_data;
   logic [KEEP_WIDTH-1:0] m_keep;
   logic [USER_WIDTH-1:0] m_user;

   logic                  out_ld, fire, crc_en, carry_en, frame_done, tlp_rdy, dllp_rdy;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [KEEP_WIDTH-1:0] beat_keep;
   logic                  beat_last;
   logic [USER_WIDTH-1:0] beat_user;

   // TLPs are whole dwords, so their tkeep carries no information.
   logic tlp_keep_unused;
   assign tlp_keep_unused = ^s_axis_tlp_tkeep_i;

   assign out_ld = !m_valid || m_axis_tready_i;

   // Bytes covered by the LCRC in the current beat; the 16-bit carry shifts TLP data by two bytes.
   always_comb begin
      crc_data = {s_axis_tlp_tdata_i[15:0], carry};
      crc_keep = 4'hF;
      case (state)
         TX_TLP_FIRST: crc_data = {s_axis_tlp_tdata_i[15:0], next_seq[7:0], 4'h0, next_seq[11:8]};
         TX_CRC_A: begin
            crc_data = {16'h0, carry};
            crc_keep = 4'b0011;
         end
         default: ;
      endcase
   end

   pcie_lcrc32 u_lcrc (
      .crc_i  (crc),
      .data_i (crc_data),
      .keep_i (crc_keep),
      .crc_o  (crc_upd)
   );

   assign lcrc_a = lcrc_final(crc_upd);
   assign lcrc_b = lcrc_final(crc);

   always_comb begin
      state_nxt  = state;
      fire       = 1'b0;
      crc_en     = 1'b0;
      carry_en   = 1'b0;
      frame_done = 1'b0;
      tlp_rdy    = 1'b0;
      dllp_rdy   = 1'b0;
      beat_data  = '0;
      beat_keep  = '0;
      beat_last  = 1'b0;
      beat_user  = '0;
      case (state)
         TX_IDLE: begin
            if (s_axis_dllp_tvalid_i && (link_status_i == DL_INIT || link_status_i == DL_ACTIVE)) begin
               state_nxt = TX_DLLP_PASS;
            end else if (s_axis_tlp_tvalid_i && link_status_i == DL_ACTIVE) begin
               state_nxt = TX_TLP_FIRST;
            end
         end
         TX_DLLP_PASS: begin
            dllp_rdy     = out_ld;
            fire         = out_ld && s_axis_dllp_tvalid_i;
            beat_data    = s_axis_dllp_tdata_i;
            beat_keep    = s_axis_dllp_tkeep_i;
            beat_last    = s_axis_dllp_tlast_i;
            beat_user[0] = 1'b1;
            if (fire && s_axis_dllp_tlast_i) state_nxt = TX_IDLE;
         end
         TX_TLP_FIRST, TX_TLP_BODY: begin
            tlp_rdy   = out_ld;
            fire      = out_ld && s_axis_tlp_tvalid_i;
            crc_en    = fire;
            carry_en  = fire;
            beat_data = crc_data;
            beat_keep = 4'hF;
            if (fire) state_nxt = s_axis_tlp_tlast_i ? TX_CRC_A : TX_TLP_BODY;
         end
         TX_CRC_A: begin
            fire      = out_ld;
            crc_en    = fire;
            beat_data = {lcrc_a[15:0], carry};
            beat_keep = 4'hF;
            if (fire) state_nxt = TX_CRC_B;
         end
         TX_CRC_B: begin
            fire       = out_ld;
            frame_done = fire;
            beat_data  = {16'h0, lcrc_b[31:16]};
            beat_keep  = 4'b0011;
            beat_last  = 1'b1;
            if (fire) state_nxt = TX_IDLE;
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state          <= TX_IDLE;
         next_seq       <= '0;
         crc            <= LCRC_SEED;
         m_valid        <= 1'b0;
         m_data         <= '0;
         m_keep         <= '0;
         m_last         <= 1'b0;
         m_user         <= '0;
         tx_seq_num_o   <= '0;
         tx_seq_valid_o <= 1'b0;
      end else begin
         state          <= state_nxt;
         tx_seq_valid_o <= frame_done;
         if (out_ld) begin
            m_valid <= fire;
            if (fire) begin
               m_data <= beat_data;
               m_keep <= beat_keep;
               m_last <= beat_last;
               m_user <= beat_user;
            end
         end
         if (crc_en) crc <= crc_upd;
         if (frame_done) begin
            crc          <= LCRC_SEED;
            tx_seq_num_o <= next_seq;
            next_seq     <= next_seq + SEQ_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (carry_en) carry <= s_axis_tlp_tdata_i[31:16];
   end

   assign s_axis_tlp_tready_o  = rst_i && tlp_rdy;
   assign s_axis_dllp_tready_o = rst_i && dllp_rdy;
   assign m_axis_tdata_o       = m_data;
   assign m_axis_tkeep_o       = m_keep;
   assign m_axis_tvalid_o      = m_valid;
   assign m_axis_tlast_o       = m_last;
   assign m_axis_tuser_o       = m_user;

endmodule

// File: tb/tb_tlp2dllp.sv
// Bench for tlp2dllp: queue-driven TLP/DLLP sources, byte-level frame model with a reflected CRC-32.
module tb_tlp2dllp;
   import pcie_datalink_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [3:0]  user;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   dl_status_e  link;
   logic [31:0] tlp_tdata, dllp_tdata, m_tdata;
   logic [3:0]  tlp_tkeep, dllp_tkeep, m_tkeep, m_tuser;
   logic        tlp_tvalid, tlp_tlast, tlp_tready;
   logic        dllp_tvalid, dllp_tlast, dllp_tready;
   logic        m_tvalid, m_tlast, m_tready;
   logic [11:0] seq_num;
   logic        seq_valid;

   int          vectors = 0;
   int          miscompares = 0;
   int          out_beats = 0;
   int          seq_pulses = 0;
   beat_t       tlp_q[$], dllp_q[$], exp_q[$], cap_q[$];
   int          exp_seq_q[$];
   logic        tlp_hs, dllp_hs;
   bit          rnd_ready = 1'b0;
   bit          hold_ready = 1'b0;
   logic [11:0] model_seq = 12'd0;

   tlp2dllp dut (
      .clk_i                (clk),
      .rst_i                (rst_n),
      .link_status_i        (link),
      .s_axis_tlp_tdata_i   (tlp_tdata),
      .s_axis_tlp_tkeep_i   (tlp_tkeep),
      .s_axis_tlp_tvalid_i  (tlp_tvalid),
      .s_axis_tlp_tlast_i   (tlp_tlast),
      .s_axis_tlp_tready_o  (tlp_tready),
      .s_axis_dllp_tdata_i  (dllp_tdata),
      .s_axis_dllp_tkeep_i  (dllp_tkeep),
      .s_axis_dllp_tvalid_i (dllp_tvalid),
      .s_axis_dllp_tlast_i  (dllp_tlast),
      .s_axis_dllp_tready_o (dllp_tready),
      .m_axis_tdata_o       (m_tdata),
      .m_axis_tkeep_o       (m_tkeep),
      .m_axis_tvalid_o      (m_tvalid),
      .m_axis_tlast_o       (m_tlast),
      .m_axis_tuser_o       (m_tuser),
      .m_axis_tready_i      (m_tready),
      .tx_seq_num_o         (seq_num),
      .tx_seq_valid_o       (seq_valid)
   );

   // Reflected CRC-32 (0xEDB88320), which is the same LCRC seen from the wire side.
   function automatic logic [31:0] crc32_bytes(input byte unsigned b[$]);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         r = r ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return ~r;
   endfunction

   task automatic queue_tlp(input int n, input bit rnd);
      byte unsigned b[$];
      logic [31:0]  dw, lc;
      beat_t        bt;
      b.push_back({4'h0, model_seq[11:8]});
      b.push_back(model_seq[7:0]);
      for (int i = 0; i < n; i++) begin
         dw = rnd ? $urandom : 32'(i + 1);
         for (int k = 0; k < 4; k++) b.push_back(dw[8*k +: 8]);
         bt = '{data: dw, keep: 4'hF, last: (i == n - 1), user: 4'h0};
         tlp_q.push_back(bt);
      end
      lc = crc32_bytes(b);
      for (int k = 0; k < 4; k++) b.push_back(lc[8*k +: 8]);
      for (int i = 0; i < b.size(); i += 4) begin
         bt = '0;
         for (int k = 0; k < 4; k++) begin
            if (i + k < b.size()) begin
               bt.data[8*k +: 8] = b[i+k];
               bt.keep[k]        = 1'b1;
            end
         end
         bt.last = (i + 4 >= b.size());
         exp_q.push_back(bt);
      end
      exp_seq_q.push_back(int'({20'd0, model_seq}));
      model_seq = model_seq + 12'd1;
   endtask

   task automatic queue_dllp(input bit front);
      beat_t d0, d1;
      d0 = '{data: $urandom, keep: 4'hF, last: 1'b0, user: 4'h1};
      d1 = '{data: $urandom, keep: 4'b0011, last: 1'b1, user: 4'h1};
      dllp_q.push_back(d0);
      dllp_q.push_back(d1);
      if (front) begin
         exp_q.push_front(d1);
         exp_q.push_front(d0);
      end else begin
         exp_q.push_back(d0);
         exp_q.push_back(d1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() + exp_seq_q.size() + tlp_q.size() + dllp_q.size()) != 0 && n < budget) begin
         step();
         n++;
      end
      vectors++;
      assert (n < budget) else begin
         miscompares++;
         $error("FAIL drain_timeout pending_beats=%0d pending_seqs=%0d after %0d cycles", exp_q.size(), exp_seq_q.size(), n);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      model_seq = 12'd0;
   endtask

   // TLP source
   initial begin
      tlp_tvalid = 1'b0; tlp_tdata = '0; tlp_tkeep = 4'hF; tlp_tlast = 1'b0; tlp_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (tlp_hs && tlp_q.size() > 0) void'(tlp_q.pop_front());
         tlp_hs = 1'b0;
         if (tlp_q.size() > 0) begin
            tlp_tvalid = 1'b1; tlp_tdata = tlp_q[0].data; tlp_tlast = tlp_q[0].last;
         end else begin
            tlp_tvalid = 1'b0; tlp_tdata = '0; tlp_tlast = 1'b0;
         end
         #4 tlp_hs = tlp_tvalid && tlp_tready;
      end
   end

   // DLLP source and output backpressure
   initial begin
      dllp_tvalid = 1'b0; dllp_tdata = '0; dllp_tkeep = '0; dllp_tlast = 1'b0; dllp_hs = 1'b0;
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (dllp_hs && dllp_q.size() > 0) void'(dllp_q.pop_front());
         dllp_hs = 1'b0;
         if (dllp_q.size() > 0) begin
            dllp_tvalid = 1'b1; dllp_tdata = dllp_q[0].data;
            dllp_tkeep = dllp_q[0].keep; dllp_tlast = dllp_q[0].last;
         end else begin
            dllp_tvalid = 1'b0; dllp_tdata = '0; dllp_tkeep = '0; dllp_tlast = 1'b0;
         end
         m_tready = hold_ready ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         #4 dllp_hs = dllp_tvalid && dllp_tready;
      end
   end

   // Output monitor, sampled one time unit before each rising edge
   initial begin
      beat_t cur, prev, e;
      bit    prev_stall;
      int    es;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #4;
         cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               vectors++;
               assert (m_tvalid === 1'b1 && cur === prev) else begin
                  miscompares++;
                  $error("FAIL stall_hold got v=%0b %h want v=1 %h", m_tvalid, cur, prev);
               end
            end
            if (m_tvalid && m_tready) begin
               out_beats++;
               cap_q.push_back(cur);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               vectors++;
               assert (cur === e) else begin
                  miscompares++;
                  $error("FAIL beat got %h want %h", cur, e);
               end
            end
            if (seq_valid) begin
               seq_pulses++;
               es = (exp_seq_q.size() > 0) ? exp_seq_q.pop_front() : -1;
               vectors++;
               assert (int'({20'd0, seq_num}) === es) else begin
                  miscompares++;
                  $error("FAIL seq_num got %0d want %0d", seq_num, es);
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev = cur;
         end
      end
   end

   initial begin
      int p0, b0;
      rst_n = 1'b0;
      link  = DL_ACTIVE;
      repeat (3) step();

      // Reset state
      vectors += 6;
      assert (m_tvalid === 1'b0) else begin miscompares++; $error("FAIL rst_tvalid got %0b want 0", m_tvalid); end
      assert ({m_tdata, m_tkeep, m_tlast, m_tuser} === 41'd0) else begin
         miscompares++; $error("FAIL rst_mbeat got %h want 0", {m_tdata, m_tkeep, m_tlast, m_tuser}); end
      assert (tlp_tready === 1'b0) else begin miscompares++; $error("FAIL rst_tlp_ready got %0b want 0", tlp_tready); end
      assert (dllp_tready === 1'b0) else begin miscompares++; $error("FAIL rst_dllp_ready got %0b want 0", dllp_tready); end
      assert (seq_valid === 1'b0) else begin miscompares++; $error("FAIL rst_seq_valid got %0b want 0", seq_valid); end
      assert (seq_num === 12'd0) else begin miscompares++; $error("FAIL rst_seq_num got %0d want 0", seq_num); end
      rst_n = 1'b1;
      step();

      // Directed 3-DW TLP with seq 0
      cap_q.delete();
      queue_tlp(3, 1'b0);
      wait_drain(100);
      vectors += 5;
      assert (cap_q.size() === 5) else begin miscompares++; $error("FAIL t1_len got %0d want 5", cap_q.size()); end
      assert (cap_q[0].data === 32'h0001_0000) else begin miscompares++; $error("FAIL t1_beat0 got %h want 00010000", cap_q[0].data); end
      assert (cap_q[1].data === 32'h0002_0000) else begin miscompares++; $error("FAIL t1_beat1 got %h want 00020000", cap_q[1].data); end
      assert (cap_q[2].data === 32'h0003_0000) else begin miscompares++; $error("FAIL t1_beat2 got %h want 00030000", cap_q[2].data); end
      assert ({cap_q[4].keep, cap_q[4].last} === 5'b0011_1) else begin
         miscompares++; $error("FAIL t1_last got keep=%b last=%0b want keep=0011 last=1", cap_q[4].keep, cap_q[4].last); end

      // DLLP and TLP valid together: DLLP first
      repeat (3) step();
      cap_q.delete();
      queue_dllp(1'b0);
      queue_tlp(2, 1'b1);
      wait_drain(100);
      vectors += 2;
      assert (cap_q.size() === 6) else begin miscompares++; $error("FAIL t3_len got %0d want 6", cap_q.size()); end
      assert (cap_q[0].user === 4'h1) else begin miscompares++; $error("FAIL t3_first_user got %h want 1", cap_q[0].user); end

      // DLLP arriving mid-TLP waits for the frame end
      b0 = out_beats;
      queue_tlp(4, 1'b1);
      for (int i = 0; i < 50 && out_beats == b0; i++) step();
      queue_dllp(1'b0);
      wait_drain(100);

      // Link in DL_INIT: TLP held, DLLP passes, then TLP with seq 0 once active
      pulse_reset();
      link = DL_INIT;
      queue_tlp(2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         vectors += 2;
         assert (tlp_tready === 1'b0) else begin miscompares++; $error("FAIL init_tlp_ready got %0b want 0", tlp_tready); end
         assert (m_tvalid === 1'b0) else begin miscompares++; $error("FAIL init_tvalid got %0b want 0", m_tvalid); end
      end
      queue_dllp(1'b1);
      repeat (20) step();
      vectors++;
      assert (exp_q.size() === 4) else begin miscompares++; $error("FAIL init_dllp_pass got pending=%0d want 4", exp_q.size()); end
      link = DL_ACTIVE;
      wait_drain(100);

      // 4097 back-to-back 1-DW TLPs: sequence wraps 4095 -> 0
      pulse_reset();
      p0 = seq_pulses;
      for (int i = 0; i < 4097; i++) queue_tlp(1, 1'b1);
      wait_drain(30000);
      vectors++;
      assert (seq_pulses - p0 === 4097) else begin miscompares++; $error("FAIL wrap_pulses got %0d want 4097", seq_pulses - p0); end

      // Random backpressure over 200 random-length TLPs
      rnd_ready = 1'b1;
      for (int i = 0; i < 200; i++) queue_tlp(int'($urandom_range(1, 8)), 1'b1);
      wait_drain(30000);
      rnd_ready = 1'b0;
      step();

      // Reset in the middle of a TLP body
      b0 = out_beats;
      queue_tlp(8, 1'b1);
      for (int i = 0; i < 50 && out_beats < b0 + 3; i++) step();
      rst_n = 1'b0;
      hold_ready = 1'b1;
      tlp_q.delete();
      tlp_hs = 1'b0;
      exp_q.delete();
      exp_seq_q.delete();
      model_seq = 12'd0;
      step();
      vectors += 2;
      assert (m_tvalid === 1'b0) else begin miscompares++; $error("FAIL midrst_tvalid got %0b want 0", m_tvalid); end
      assert (seq_valid === 1'b0) else begin miscompares++; $error("FAIL midrst_seq_valid got %0b want 0", seq_valid); end
      rst_n = 1'b1;
      hold_ready = 1'b0;
      step();
      p0 = seq_pulses;
      queue_tlp(2, 1'b1);
      wait_drain(100);
      vectors++;
      assert (seq_pulses - p0 === 1) else begin miscompares++; $error("FAIL midrst_pulses got %0d want 1", seq_pulses - p0); end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
